// File: rtl/keypad_pkg.sv
// Shared types and constants for the 4x4 keypad scanning path.
package keypad_pkg;

    // Scanner control states.
    typedef enum logic [1:0] {
        SCAN,
        DEBOUNCE,
        REPORT,
        HOLD
    } state_t;

    localparam int          NUM_ROWS = 4;
    localparam int          NUM_COLS = 4;
    localparam logic [3:0]  COL_IDLE = 4'b1111;

    // True when exactly one column line is pulled low (a single key on the driven row).
    function automatic logic one_cold(input logic [3:0] cols);
        return ($countones(~cols) == 1);
    endfunction

endpackage

// File: rtl/col_sync.sv
// Two-flop synchroniser for the asynchronous, active-low column lines.
// Resets to all-ones so no phantom key press is seen while in reset.
module col_sync #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] meta;

    // Two-stage capture of the raw lines into the clk domain.
    always_ff @(posedge clk) begin
        // NOTE: state registers use non-blocking assignments so both stages
        // sample their old values on the same edge and form a real 2-deep chain.
        if (rst) begin
            meta <= '1;
            dout <= '1;
        end else begin
            meta <= din;
            dout <= meta;
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 keypad matrix scanner: drives rows one at a time, debounces a single
// pressed key, reports it once, then waits for a debounced release.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV        = 4,
    parameter int DEBOUNCE_CYCLES = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [NUM_COLS-1:0] col_n,
    output logic [NUM_ROWS-1:0] row_n,
    output logic [1:0]          row_idx,
    output logic [NUM_COLS-1:0] col_pat,
    output logic                key_valid,
    output logic                key_held
);

    localparam int DW = $clog2(SCAN_DIV);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
    localparam logic [CW-1:0] CNT_LAST   = CW'(DEBOUNCE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_MAX    = CW'(DEBOUNCE_CYCLES);
    localparam logic [CW-1:0] CNT_ONE    = CW'(1);

    logic [NUM_COLS-1:0] col_s;

    state_t              state,   state_nx;
    logic [1:0]          cur_row, cur_row_nx;
    logic [DW-1:0]       dwell,   dwell_nx;
    logic [CW-1:0]       deb_cnt, deb_nx;
    logic [CW-1:0]       rel_cnt, rel_nx;
    logic [NUM_COLS-1:0] cand,    cand_nx;
    logic [1:0]          row_idx_nx;
    logic [NUM_COLS-1:0] col_pat_nx;

    col_sync #(
        .WIDTH (NUM_COLS)
    ) u_col_sync (
        .clk  (clk),
        .rst  (rst),
        .din  (col_n),
        .dout (col_s)
    );

    // Next-state and counter logic; every decision looks only at the synchronised columns.
    always_comb begin
        // NOTE: every signal written here gets a default first, so no path
        // through the case statement can leave one unassigned and infer a latch.
        state_nx   = state;
        cur_row_nx = cur_row;
        dwell_nx   = dwell;
        deb_nx     = deb_cnt;
        rel_nx     = rel_cnt;
        cand_nx    = cand;
        row_idx_nx = row_idx;
        col_pat_nx = col_pat;

        unique case (state)
            SCAN: begin
                if (dwell == DWELL_LAST) begin
                    dwell_nx = '0;
                    if (one_cold(col_s)) begin
                        // Single key on this row: freeze the row and start debouncing.
                        cand_nx  = col_s;
                        deb_nx   = CNT_ONE;
                        state_nx = DEBOUNCE;
                    end else begin
                        // Idle or ghosting pattern: move on to the next row.
                        cur_row_nx = cur_row + 2'd1;
                    end
                end else begin
                    dwell_nx = dwell + 1'b1;
                end
            end

            DEBOUNCE: begin
                if (col_s != cand) begin
                    // Bounce or change of key: rescan the same row from the start.
                    state_nx = SCAN;
                    dwell_nx = '0;
                    deb_nx   = '0;
                end else if (deb_cnt >= CNT_LAST) begin
                    // Counter reaches its terminal value on this edge; latch the report.
                    deb_nx     = CNT_MAX;
                    state_nx   = REPORT;
                    row_idx_nx = cur_row;
                    col_pat_nx = cand;
                end else begin
                    deb_nx = deb_cnt + 1'b1;
                end
            end

            REPORT: begin
                deb_nx   = '0;
                rel_nx   = '0;
                state_nx = HOLD;
            end

            HOLD: begin
                if (col_s != COL_IDLE) begin
                    // Any column still low (original or a second key) restarts the release count.
                    rel_nx = '0;
                end else if (rel_cnt >= CNT_LAST) begin
                    rel_nx     = '0;
                    state_nx   = SCAN;
                    cur_row_nx = cur_row + 2'd1;
                    dwell_nx   = '0;
                end else begin
                    rel_nx = rel_cnt + 1'b1;
                end
            end

            default: begin
                state_nx = SCAN;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= SCAN;
            cur_row <= '0;
            dwell   <= '0;
            deb_cnt <= '0;
            rel_cnt <= '0;
            cand    <= COL_IDLE;
            row_idx <= '0;
            col_pat <= COL_IDLE;
        end else begin
            state   <= state_nx;
            cur_row <= cur_row_nx;
            dwell   <= dwell_nx;
            deb_cnt <= deb_nx;
            rel_cnt <= rel_nx;
            cand    <= cand_nx;
            row_idx <= row_idx_nx;
            col_pat <= col_pat_nx;
        end
    end

    // Row drive and status flags decode directly from registered state.
    always_comb begin
        row_n     = ~(4'b0001 << cur_row);
        key_valid = (state == REPORT);
        key_held  = (state == REPORT) || (state == HOLD);
    end

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner: a behavioural 4x4 key matrix drives the
// columns from the row drive, and expectations come from which keys are pressed.
module tb_keypad_scanner;

    localparam int SCAN_DIV        = 4;
    localparam int DEBOUNCE_CYCLES = 8;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] col_n;
    logic [3:0] row_n;
    logic [1:0] row_idx;
    logic [3:0] col_pat;
    logic       key_valid;
    logic       key_held;

    int         n_checks = 0;
    int         n_fail   = 0;
    int         n_valid  = 0;
    logic [1:0] last_row = '0;
    logic [3:0] last_col = '1;

    // Pressed keys of the matrix model: bit r*4+c is key (row r, column c).
    logic [15:0] pressed   = '0;
    logic        force_en  = 1'b0;
    logic [3:0]  force_val = 4'b1111;

    keypad_scanner #(
        .SCAN_DIV        (SCAN_DIV),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .col_n     (col_n),
        .row_n     (row_n),
        .row_idx   (row_idx),
        .col_pat   (col_pat),
        .key_valid (key_valid),
        .key_held  (key_held)
    );

    always #5 clk = ~clk;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Column lines seen by a real pulled-up matrix: a column is low if any pressed
    // key on it sits on a row that is currently driven low.
    function automatic logic [3:0] keypad_cols(input logic [3:0] rows_n, input logic [15:0] keys);
        logic [3:0] cols = 4'b1111;
        for (int r = 0; r < 4; r++)
            for (int c = 0; c < 4; c++)
                if (!rows_n[r] && keys[r*4+c]) cols[c] = 1'b0;
        return cols;
    endfunction

    function automatic logic [3:0] one_low(input int idx);
        logic [3:0] v = 4'b0001;
        v = v << idx;
        return ~v;
    endfunction

    // One clock: sample outputs just after the edge, then update the column lines.
    task automatic step();
        @(posedge clk);
        #1;
        if (key_valid === 1'b1) begin
            n_valid++;
            last_row = row_idx;
            last_col = col_pat;
        end
        check("row_one_cold", $countones(~row_n), 1);
        col_n = force_en ? force_val : keypad_cols(row_n, pressed);
    endtask

    task automatic do_reset();
        force_en  = 1'b1;
        force_val = 4'b0000;
        col_n     = 4'b0000;
        rst       = 1'b1;
        repeat (3) step();
        rst      = 1'b0;
        force_en = 1'b0;
        col_n    = keypad_cols(row_n, pressed);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_row_n"},     row_n,     4'b1110);
        check({tag, "_row_idx"},   row_idx,   0);
        check({tag, "_col_pat"},   col_pat,   4'b1111);
        check({tag, "_key_valid"}, key_valid, 0);
        check({tag, "_key_held"},  key_held,  0);
    endtask

    // Press key (r,c), wait for its report, keep holding, and confirm a single report.
    task automatic press_key(input int r, input int c, input int hold, input string tag);
        int start = n_valid;
        int waited = 0;
        bit seen = 1'b0;
        pressed[r*4+c] = 1'b1;
        while (!seen && waited < 64) begin
            step();
            waited++;
            if (n_valid != start) seen = 1'b1;
        end
        check({tag, "_reported"}, seen, 1);
        check({tag, "_row_idx"}, last_row, r);
        check({tag, "_col_pat"}, last_col, one_low(c));
        check({tag, "_held_at_report"}, key_held, 1);
        repeat (hold) step();
        check({tag, "_single_report"}, n_valid - start, 1);
        check({tag, "_held"}, key_held, 1);
        check({tag, "_pattern_stable"}, col_pat, one_low(c));
    endtask

    // Release every key and wait for the debounced release; scanning resumes on the next row.
    task automatic release_keys(input int next_row, input string tag);
        int waited = 0;
        pressed = '0;
        while (key_held === 1'b1 && waited < 40) begin
            step();
            waited++;
        end
        check({tag, "_released"}, key_held, 0);
        check({tag, "_resume_row"}, row_n, one_low(next_row));
    endtask

    initial begin
        int base;
        int changes;
        logic [3:0] prev_row;

        rst   = 1'b1;
        col_n = 4'b1111;

        // Reset with all columns low: reset values, then free-running row scan.
        do_reset();
        check_reset_values("reset");
        check("scan_k0", row_n, 4'b1110);
        for (int k = 1; k < 20; k++) begin
            step();
            check($sformatf("scan_k%0d", k), row_n, one_low((k / SCAN_DIV) % 4));
        end

        // Clean single press on row 2, column 1.
        press_key(2, 1, 10, "clean");
        release_keys(3, "clean");

        // Bouncing contact on row 0 column 0, then a stable hold.
        base = n_valid;
        for (int i = 0; i < 40; i++) begin
            if (i % 3 == 0) pressed[0] = ~pressed[0];
            step();
        end
        check("bounce_no_report", n_valid - base, 0);
        press_key(0, 0, 5, "bounce_hold");
        release_keys(1, "bounce");

        // Two keys on the same row: rejected, scanning never stalls.
        base = n_valid;
        pressed[4] = 1'b1;
        pressed[5] = 1'b1;
        changes  = 0;
        prev_row = row_n;
        repeat (48) begin
            step();
            if (row_n != prev_row) changes++;
            prev_row = row_n;
        end
        check("multi_no_report", n_valid - base, 0);
        check("multi_not_held", key_held, 0);
        check("multi_row_changes", changes, 48 / SCAN_DIV);
        pressed = '0;

        // Long hold on row 3 column 3, then a second key on the same row.
        base = n_valid;
        press_key(3, 3, 200, "long");
        pressed[12] = 1'b1;
        repeat (30) step();
        check("second_key_no_report", n_valid - base, 1);
        check("second_key_held", key_held, 1);
        check("second_key_pattern", col_pat, 4'b0111);
        release_keys(0, "long");

        // Random single-key presses with random hold and idle lengths.
        for (int n = 0; n < 6; n++) begin
            int r = $urandom_range(0, 3);
            int c = $urandom_range(0, 3);
            press_key(r, c, $urandom_range(0, 25), $sformatf("rand%0d", n));
            release_keys((r + 1) % 4, $sformatf("rand%0d", n));
            repeat ($urandom_range(0, 30)) step();
        end

        // Reset while debouncing a press on row 0 column 1.
        pressed = '0;
        pressed[1] = 1'b1;
        do_reset();
        base = n_valid;
        repeat (8) step();
        check("deb_row_frozen", row_n, 4'b1110);
        check("deb_not_reported", n_valid - base, 0);
        rst = 1'b1;
        step();
        check_reset_values("rst_deb");
        check("rst_deb_no_pulse", n_valid - base, 0);
        pressed = '0;
        step();
        rst = 1'b0;

        // Reset while holding a reported key.
        press_key(2, 2, 5, "hold_pre_rst");
        base = n_valid;
        rst = 1'b1;
        step();
        check_reset_values("rst_hold");
        check("rst_hold_no_pulse", n_valid - base, 0);
        pressed = '0;
        rst = 1'b0;
        step();
        check("after_rst_not_held", key_held, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
